cpu_program_loader: RTL and testbench

- Test/boot harness that sits directly upstream of the cpu top and drives its external memory ports and its enable input.
- Consumes a 32-bit valid/ready word stream that carries a program image, initial data, and a run length.
- Sequence: hold the cpu in reset, write instruction memory and data memory, run the cpu for N cycles, then stream the data-memory contents back out on a 64-bit valid/ready port.

---
 rtl/cpu_program_loader_pkg.sv | 31 +++
 rtl/loader_dump_channel.sv | 75 +++++++
 rtl/cpu_program_loader.sv | 152 +++++++++++++++
 tb/tb_cpu_program_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_program_loader_pkg.sv
// Shared types and constants for the cpu program loader and its dump channel.
package cpu_program_loader_pkg;

  localparam int IMEM_SHIFT = 2;
  localparam int DMEM_SHIFT = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_I,
    S_HDR_D,
    S_LOAD_D_LO,
    S_LOAD_D_HI,
    S_HDR_C,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RD,
    D_WAIT,
    D_OUT
  } dump_state_t;

  // Word index to byte address: zero-extended, then scaled by the word size.
  function automatic logic [63:0] byte_addr(input logic [31:0] idx, input int shift);
    return 64'(idx) << shift;
  endfunction

endpackage

// File: rtl/loader_dump_channel.sv
// Read-and-hold sequencer: reads len words from a synchronous memory and
// presents each one on a valid/ready stream, holding it until accepted.
module loader_dump_channel
  import cpu_program_loader_pkg::*;
#(
  parameter int DW    = 64,
  parameter int SHIFT = DMEM_SHIFT
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          start,
  input  logic [31:0]   len,
  output logic          ren,
  output logic [63:0]   addr,
  input  logic [DW-1:0] rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          done
);

  dump_state_t state, state_next;
  logic [31:0] idx, len_q;
  logic        last;

  assign last = (idx + 32'd1) == len_q;
  assign ren  = (state == D_RD);
  assign addr = ren ? byte_addr(idx, SHIFT) : '0;
  assign done = (state == D_OUT) && m_ready && last;

  // NOTE: clocked blocks use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= D_IDLE;
    else         state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      D_IDLE: if (start && len != 32'd0) state_next = D_RD;
      D_RD:   state_next = D_WAIT;
      D_WAIT: state_next = D_OUT;
      D_OUT:  if (m_ready) state_next = last ? D_IDLE : D_RD;
      default: state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx     <= '0;
      len_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        D_IDLE: if (start) begin
          len_q <= len;
          idx   <= '0;
        end
        D_WAIT: begin
          m_data  <= rdata;
          m_valid <= 1'b1;
        end
        D_OUT: if (m_ready) begin
          m_valid <= 1'b0;
          m_data  <= '0;
          idx     <= last ? 32'd0 : idx + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_program_loader.sv
// Boot harness: loads imem/dmem from a word stream, runs the cpu for C cycles,
// then streams the data memory back out.
module cpu_program_loader
  import cpu_program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        cpu_arst_n,
  output logic        enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        err
);

  state_t state, state_next;
  logic [31:0]      ni, nd, idx_i, idx_d, lo_word, dump_len;
  logic [CNT_W-1:0] run_cnt;
  logic             xfer, run_last, dump_start, dump_done, dump_ren;
  logic [63:0]      dump_addr;

  assign s_ready  = state inside {S_IDLE, S_LOAD_I, S_HDR_D, S_LOAD_D_LO, S_LOAD_D_HI, S_HDR_C};
  assign xfer     = s_valid && s_ready;
  assign busy     = !(state inside {S_IDLE, S_DONE});
  assign run_last = (state == S_RUN) && enable && (run_cnt == CNT_W'(1));
  assign dump_len = (nd > 32'(DMEM_WORDS)) ? 32'(DMEM_WORDS) : nd;
  assign dump_start = (nd != 32'd0) &&
                      (run_last || (state == S_HDR_C && xfer && s_data == 32'd0));

  // Writes beyond capacity still consume the stream word but never reach memory.
  assign wen_ext     = (state == S_LOAD_I) && xfer && (idx_i < 32'(IMEM_WORDS));
  assign addr_ext    = wen_ext ? byte_addr(idx_i, IMEM_SHIFT) : '0;
  assign wdata_ext   = wen_ext ? s_data : '0;
  assign ren_ext     = 1'b0;
  assign wen_ext_2   = (state == S_LOAD_D_HI) && xfer && (idx_d < 32'(DMEM_WORDS));
  assign addr_ext_2  = wen_ext_2 ? byte_addr(idx_d, DMEM_SHIFT) : dump_addr;
  assign wdata_ext_2 = wen_ext_2 ? {s_data, lo_word} : '0;
  assign ren_ext_2   = dump_ren;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (xfer) state_next = (s_data == 32'd0) ? S_HDR_D : S_LOAD_I;
      S_LOAD_I:    if (xfer && (idx_i + 32'd1) == ni) state_next = S_HDR_D;
      S_HDR_D:     if (xfer) state_next = (s_data == 32'd0) ? S_HDR_C : S_LOAD_D_LO;
      S_LOAD_D_LO: if (xfer) state_next = S_LOAD_D_HI;
      S_LOAD_D_HI: if (xfer) state_next = ((idx_d + 32'd1) == nd) ? S_HDR_C : S_LOAD_D_LO;
      S_HDR_C: if (xfer) begin
        if (s_data != 32'd0)  state_next = S_RUN;
        else if (nd != 32'd0) state_next = S_DUMP;
        else                  state_next = S_DONE;
      end
      S_RUN:   if (run_last) state_next = (nd != 32'd0) ? S_DUMP : S_DONE;
      S_DUMP:  if (dump_done) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ni         <= '0;
      nd         <= '0;
      idx_i      <= '0;
      idx_d      <= '0;
      lo_word    <= '0;
      run_cnt    <= '0;
      cpu_arst_n <= 1'b0;
      enable     <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (xfer) begin
          ni    <= s_data;
          idx_i <= '0;
          if (s_data > 32'(IMEM_WORDS)) err <= 1'b1;
        end
        S_LOAD_I: if (xfer) idx_i <= idx_i + 32'd1;
        S_HDR_D: if (xfer) begin
          nd    <= s_data;
          idx_d <= '0;
          if (s_data > 32'(DMEM_WORDS)) err <= 1'b1;
        end
        S_LOAD_D_LO: if (xfer) lo_word <= s_data;
        S_LOAD_D_HI: if (xfer) idx_d <= idx_d + 32'd1;
        S_HDR_C: if (xfer) begin
          run_cnt <= CNT_W'(s_data);
          if (s_data != 32'd0) cpu_arst_n <= 1'b1;
        end
        // The cpu leaves reset on the first RUN cycle; enable follows one cycle later.
        S_RUN: begin
          if (!enable) enable <= 1'b1;
          else begin
            run_cnt <= run_cnt - CNT_W'(1);
            if (run_last) enable <= 1'b0;
          end
        end
        S_DONE: begin
          cpu_arst_n <= 1'b0;
          enable     <= 1'b0;
          ni         <= '0;
          nd         <= '0;
          idx_i      <= '0;
          idx_d      <= '0;
          lo_word    <= '0;
          run_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  loader_dump_channel #(
    .DW    (64),
    .SHIFT (DMEM_SHIFT)
  ) u_dump (
    .clk     (clk),
    .arst_n  (arst_n),
    .start   (dump_start),
    .len     (dump_len),
    .ren     (dump_ren),
    .addr    (dump_addr),
    .rdata   (rdata_ext_2),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .done    (dump_done)
  );

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scenario bench for cpu_program_loader with a synchronous dmem model and a dump scoreboard.
module tb_cpu_program_loader;

  localparam int IMEM = 128;
  localparam int DMEM = 128;

  logic        clk, arst_n;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [63:0] m_data;
  logic        cpu_arst_n, enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic        busy, err;

  cpu_program_loader #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_arst_n(cpu_arst_n), .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dmem model: read data appears the cycle after ren_ext_2.
  logic [63:0] dmem [0:DMEM-1];
  always @(posedge clk) begin
    if (wen_ext_2 && (addr_ext_2 >> 3) < 64'(DMEM)) dmem[addr_ext_2[9:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= ((addr_ext_2 >> 3) < 64'(DMEM)) ? dmem[addr_ext_2[9:3]] : 64'hDEAD;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0]  exp_q[$];
  logic [31:0]  iw_q[$];
  logic [63:0]  dw_q[$];
  logic [95:0]  imem_q[$];
  logic [127:0] dwr_q[$];
  logic [63:0]  ren_q[$];
  int cyc = 0, en_cycles = 0, en_rises = 0, en_rise_cyc = 0, cpu_rise_cyc = 0;
  int mvalid_cycles = 0, stab_viol = 0;
  logic en_prev = 0, cpu_prev = 0, mv_prev = 0, mr_prev = 0;
  logic [63:0] md_prev = 0;

  always @(negedge clk) begin
    cyc++;
    if (wen_ext)   imem_q.push_back({addr_ext, wdata_ext});
    if (wen_ext_2) dwr_q.push_back({addr_ext_2, wdata_ext_2});
    if (ren_ext_2) ren_q.push_back(addr_ext_2);
    if (enable) en_cycles++;
    if (enable && !en_prev) begin en_rises++; en_rise_cyc = cyc; end
    if (cpu_arst_n && !cpu_prev) cpu_rise_cyc = cyc;
    if (m_valid) mvalid_cycles++;
    if (mv_prev && !mr_prev && (!m_valid || m_data !== md_prev)) stab_viol++;
    en_prev = enable; cpu_prev = cpu_arst_n;
    mv_prev = m_valid; mr_prev = m_ready; md_prev = m_data;
  end

  task automatic clear_logs();
    imem_q.delete(); dwr_q.delete(); ren_q.delete();
    en_cycles = 0; en_rises = 0; en_rise_cyc = 0; cpu_rise_cyc = 0;
    mvalid_cycles = 0; stab_viol = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic acc;
    bit   ok;
    ok = 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) begin s_data = $urandom; @(posedge clk); #1; end
    end
    s_valid = 1'b1;
    s_data  = w;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    s_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: word %08h never accepted", w);
    end
  endtask

  task automatic send_frame(input logic [31:0] c, input bit rand_gaps);
    send_word(32'(iw_q.size()), 0);
    foreach (iw_q[i]) send_word(iw_q[i], 0);
    send_word(32'(dw_q.size()), 0);
    foreach (dw_q[j]) begin
      send_word(dw_q[j][31:0],  rand_gaps ? int'($urandom_range(0, 3)) : 0);
      send_word(dw_q[j][63:32], rand_gaps ? int'($urandom_range(0, 3)) : 0);
      if (j < DMEM) exp_q.push_back(dw_q[j]);
    end
    send_word(c, 0);
  endtask

  task automatic collect_dump(input int n, input int stall_idx, input int stall_len);
    logic [63:0] got, exp;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 2000 && !m_valid; t++) begin @(posedge clk); #1; end
      if (!m_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL dump_timeout: word %0d never valid", i);
        return;
      end
      if (i == stall_idx) repeat (stall_len) begin @(posedge clk); #1; end
      m_ready = 1'b1;
      @(negedge clk); got = m_data;
      @(posedge clk); #1;
      m_ready = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL dump_word%0d: got %016h want %016h", i, got, exp); end
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 1000 && busy; t++) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: busy %b want 0", busy); end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rdata_ext_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    n_cmp++; if (cpu_arst_n !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_arst_n: got %b want 0", cpu_arst_n); end
    n_cmp++;
    if ({m_valid, enable, busy, err, wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 8'b0 ||
        m_data !== 64'b0 || addr_ext !== 64'b0 || addr_ext_2 !== 64'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got flags %b m_data %h addr %h/%h want all 0",
               {m_valid, enable, busy, err, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, m_data, addr_ext, addr_ext_2);
    end
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_logs();
    iw_q = '{32'h0050_0093, 32'h0000_0013};
    dw_q = '{64'h0000_0000_0000_0001};
    send_frame(32'd5, 0);
    collect_dump(1, -1, 0);
    wait_idle();
    n_cmp++; if (imem_q.size() != 2) begin n_bad++; $display("FAIL basic_imem_count: got %0d want 2", imem_q.size()); end
    else begin
      n_cmp++; if (imem_q[0] !== {64'd0, 32'h0050_0093}) begin n_bad++; $display("FAIL basic_imem0: got %h", imem_q[0]); end
      n_cmp++; if (imem_q[1] !== {64'd4, 32'h0000_0013}) begin n_bad++; $display("FAIL basic_imem1: got %h", imem_q[1]); end
    end
    n_cmp++; if (dwr_q.size() != 1 || dwr_q[0] !== {64'd0, 64'h1}) begin
      n_bad++; $display("FAIL basic_dmem_write: got %0d writes, first %h want 1 write {0,1}", dwr_q.size(), dwr_q.size() > 0 ? dwr_q[0] : 128'h0);
    end
    n_cmp++; if (en_cycles != 5 || en_rises != 1) begin n_bad++; $display("FAIL basic_enable: got %0d cycles %0d rises want 5/1", en_cycles, en_rises); end
    n_cmp++; if (en_rise_cyc != cpu_rise_cyc + 1) begin n_bad++; $display("FAIL basic_cpu_rst_lead: cpu rise %0d enable rise %0d want lead of 1", cpu_rise_cyc, en_rise_cyc); end
    n_cmp++; if (ren_q.size() != 1) begin n_bad++; $display("FAIL basic_ren_count: got %0d want 1", ren_q.size()); end
    n_cmp++; if (cpu_arst_n !== 1'b0 || enable !== 1'b0 || s_ready !== 1'b1) begin
      n_bad++; $display("FAIL basic_back_idle: cpu_arst_n %b enable %b s_ready %b want 0 0 1", cpu_arst_n, enable, s_ready);
    end
  endtask

  task automatic test_zero();
    clear_logs();
    send_word(32'd0, 0);
    send_word(32'd0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy_hdr_c: got %b want 1", busy); end
    send_word(32'd0, 0);
    n_cmp++; if (busy !== 1'b0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL zero_done: busy %b s_ready %b want 0 0", busy, s_ready); end
    @(posedge clk); #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL zero_idle: s_ready %b want 1", s_ready); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (en_cycles != 0 || mvalid_cycles != 0 || dwr_q.size() != 0) begin
      n_bad++; $display("FAIL zero_activity: enable %0d m_valid %0d writes %0d want 0", en_cycles, mvalid_cycles, dwr_q.size());
    end
  endtask

  task automatic test_dump_stall();
    clear_logs();
    iw_q = '{32'h0000_0013};
    dw_q = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    send_frame(32'd2, 0);
    collect_dump(3, 1, 4);
    wait_idle();
    n_cmp++; if (ren_q.size() != 3) begin n_bad++; $display("FAIL stall_ren_count: got %0d want 3", ren_q.size()); end
    else begin
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (ren_q[j] !== 64'(8 * j)) begin n_bad++; $display("FAIL stall_ren_addr%0d: got %0h want %0h", j, ren_q[j], 8 * j); end
      end
    end
    n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL stall_stability: got %0d violations want 0", stab_viol); end
  endtask

  task automatic test_rand_valid();
    clear_logs();
    iw_q.delete();
    dw_q = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    send_frame(32'd0, 1);
    collect_dump(4, -1, 0);
    wait_idle();
    n_cmp++; if (dwr_q.size() != 4) begin n_bad++; $display("FAIL rand_write_count: got %0d want 4", dwr_q.size()); end
    else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++; if (dwr_q[j] !== {64'(8 * j), dw_q[j]}) begin n_bad++; $display("FAIL rand_write%0d: got %h want %h", j, dwr_q[j], {64'(8 * j), dw_q[j]}); end
      end
    end
    n_cmp++; if (en_cycles != 0) begin n_bad++; $display("FAIL rand_enable: got %0d want 0", en_cycles); end
  endtask

  task automatic test_overflow();
    clear_logs();
    iw_q.delete();
    for (int i = 0; i < IMEM + 2; i++) iw_q.push_back($urandom);
    dw_q = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    send_frame(32'd1, 0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", err); end
    collect_dump(2, -1, 0);
    wait_idle();
    n_cmp++; if (imem_q.size() != IMEM) begin n_bad++; $display("FAIL ovf_write_count: got %0d want %0d", imem_q.size(), IMEM); end
    else begin
      n_cmp++; if (imem_q[IMEM-1] !== {64'(4 * (IMEM - 1)), iw_q[IMEM-1]}) begin
        n_bad++; $display("FAIL ovf_last_write: got %h want %h", imem_q[IMEM-1], {64'(4 * (IMEM - 1)), iw_q[IMEM-1]});
      end
    end
    n_cmp++; if (en_cycles != 1) begin n_bad++; $display("FAIL ovf_enable: got %0d want 1", en_cycles); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_run();
    clear_logs();
    iw_q = '{32'h0010_0093};
    dw_q = '{64'h0000_0000_0000_ABCD};
    send_frame(32'd5, 0);
    for (int t = 0; t < 100 && !enable; t++) begin @(posedge clk); #1; end
    n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL rr_enable_start: got %b want 1", enable); end
    repeat (2) begin @(posedge clk); #1; end
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if (enable !== 1'b0 || cpu_arst_n !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_async_reset: enable %b cpu_arst_n %b s_ready %b err %b busy %b want 0 0 1 0 0",
               enable, cpu_arst_n, s_ready, err, busy);
    end
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    clear_logs();
    iw_q = '{32'h0020_0113, 32'h0000_0013};
    dw_q = '{64'h1234_5678_9ABC_DEF0};
    send_frame(32'd3, 0);
    collect_dump(1, -1, 0);
    wait_idle();
    n_cmp++; if (imem_q.size() != 2 || imem_q[0] !== {64'd0, 32'h0020_0113} || imem_q[1] !== {64'd4, 32'h0000_0013}) begin
      n_bad++; $display("FAIL rr_reload_imem: got %0d writes want 2 at 0/4", imem_q.size());
    end
    n_cmp++; if (en_cycles != 3) begin n_bad++; $display("FAIL rr_reload_enable: got %0d want 3", en_cycles); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_dump_stall();
    test_rand_valid();
    test_overflow();
    test_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
